// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP classifier front end: loader state encoding,
// result record, default feature geometry and the error label.
package mlp_pkg;

    localparam int         NUM_FEATURES_DEF = 63;
    localparam int         FEATURE_W_DEF    = 8;
    localparam logic [7:0] LABEL_ERR        = 8'hFF;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_START,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } loader_state_t;

    // Result presented downstream: error flag plus label.
    typedef struct packed {
        logic       err;
        logic [7:0] label;
    } loader_result_t;

    function automatic loader_result_t err_result();
        loader_result_t r;
        r.err   = 1'b1;
        r.label = LABEL_ERR;
        return r;
    endfunction

endpackage

// File: rtl/mlp_feature_buffer.sv
// Feature vector register: byte-indexed write, feature k lands in bits
// [k*FEATURE_W +: FEATURE_W] so the first byte of a sample sits in the LSBs.
module mlp_feature_buffer #(
    parameter int NUM_FEATURES = 63,
    parameter int FEATURE_W    = 8,
    parameter int IDX_W        = $clog2(NUM_FEATURES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [IDX_W-1:0]                  index,
    input  logic [FEATURE_W-1:0]              data,
    output logic [NUM_FEATURES*FEATURE_W-1:0] vector
);

    // Write the addressed feature slot; all other slots keep their contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vector <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                if (index == IDX_W'(i))
                    vector[i*FEATURE_W +: FEATURE_W] <= data;
            end
        end
    end

endmodule

// File: rtl/mlp_feature_loader.sv
// Upstream loader for the MLP classifier: assembles a sample byte stream into
// the MLP feature vector, issues start, captures the label and hands it on
// over a valid/ready port. Frame errors (short/long) yield label 8'hFF.
// Optional WAIT watchdog: define MLP_LOADER_TIMEOUT_EN.
module mlp_feature_loader
    import mlp_pkg::*;
#(
    parameter int NUM_FEATURES   = NUM_FEATURES_DEF,
    parameter int FEATURE_W      = FEATURE_W_DEF,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    input  logic [FEATURE_W-1:0]              s_data,
    input  logic                              s_last,
    output logic                              s_ready,
    output logic [NUM_FEATURES*FEATURE_W-1:0] mlp_inp,
    output logic                              mlp_start,
    input  logic                              mlp_ready,
    input  logic [7:0]                        mlp_label,
    output logic                              m_valid,
    output logic [7:0]                        m_label,
    output logic                              m_err,
    input  logic                              m_ready,
    output logic                              busy
);

    localparam int               IDX_W    = $clog2(NUM_FEATURES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    loader_state_t  state;
    loader_state_t  after_hold;   // where to go once the result is taken
    logic [IDX_W-1:0] count;
    logic           seen_low;     // MLP has dropped ready since our start
    loader_result_t res;
    logic           accept;
    logic           wd_expire;

    assign s_ready = (state == ST_FILL) || (state == ST_DRAIN);
    assign busy    = (state != ST_FILL);
    assign accept  = s_valid && s_ready;
    assign m_label = res.label;
    assign m_err   = res.err;

    mlp_feature_buffer #(
        .NUM_FEATURES (NUM_FEATURES),
        .FEATURE_W    (FEATURE_W),
        .IDX_W        (IDX_W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .we     (accept && (state == ST_FILL)),
        .index  (count),
        .data   (s_data),
        .vector (mlp_inp)
    );

`ifdef MLP_LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog;

    // Watchdog counts WAIT cycles; held at zero elsewhere so each WAIT starts fresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wdog <= '0;
        else if (state == ST_WAIT)
            wdog <= wdog + 1'b1;
        else
            wdog <= '0;
    end

    assign wd_expire = (state == ST_WAIT) && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: WAIT never expires (TIMEOUT_CYCLES only matters with it).
    assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

    // Loader FSM with registered start pulse and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_FILL;
            after_hold <= ST_FILL;
            count      <= '0;
            seen_low   <= 1'b0;
            mlp_start  <= 1'b0;
            m_valid    <= 1'b0;
            res        <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        if (count == LAST_IDX) begin
                            if (s_last) begin
                                // Issue the pulse in the first START cycle when the MLP is idle.
                                state     <= ST_START;
                                mlp_start <= mlp_ready;
                            end else begin
                                state      <= ST_HOLD;
                                after_hold <= ST_DRAIN;
                                res        <= err_result();
                                m_valid    <= 1'b1;
                            end
                        end else if (s_last) begin
                            state      <= ST_HOLD;
                            after_hold <= ST_FILL;
                            res        <= err_result();
                            m_valid    <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    seen_low <= 1'b0;
                    if (mlp_start) begin
                        mlp_start <= 1'b0;
                        state     <= ST_WAIT;
                    end else if (mlp_ready) begin
                        mlp_start <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Completion needs a ready edge after our start; it beats the watchdog.
                    if (mlp_ready && seen_low) begin
                        res.err    <= 1'b0;
                        res.label  <= mlp_label;
                        m_valid    <= 1'b1;
                        after_hold <= ST_FILL;
                        state      <= ST_HOLD;
                    end else if (wd_expire) begin
                        res        <= err_result();
                        m_valid    <= 1'b1;
                        after_hold <= ST_FILL;
                        state      <= ST_HOLD;
                    end else if (!mlp_ready) begin
                        seen_low <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        count   <= '0;
                        state   <= after_hold;
                    end
                end
                ST_DRAIN: begin
                    if (accept && s_last)
                        state <= ST_FILL;
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_feature_loader.sv
// Self-checking bench for mlp_feature_loader: directed frames, a behavioural
// MLP responder, and a scoreboard of expected results/feature vectors.
module tb_mlp_feature_loader;

    localparam int NF = 63;
    localparam int FW = 8;

    logic              clk, rst;
    logic              s_valid, s_last, s_ready;
    logic [FW-1:0]     s_data;
    logic [NF*FW-1:0]  mlp_inp;
    logic              mlp_start, mlp_ready;
    logic [7:0]        mlp_label;
    logic              m_valid, m_err, m_ready, busy;
    logic [7:0]        m_label;

    mlp_feature_loader #(.NUM_FEATURES(NF), .FEATURE_W(FW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .mlp_inp(mlp_inp), .mlp_start(mlp_start), .mlp_ready(mlp_ready),
        .mlp_label(mlp_label), .m_valid(m_valid), .m_label(m_label), .m_err(m_err),
        .m_ready(m_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int rise_cyc  = 0;
    bit rise_pending = 0;
    bit prev_start = 0;
    bit hang = 0;
    int lat = 10;
    logic [7:0] cur_label = 8'h00;
    logic [7:0] fbuf [0:127];
    logic [8:0]       exp_res [$];   // {err, label}
    logic [NF*FW-1:0] exp_vec [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [NF*FW-1:0] act, input logic [NF*FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural MLP: drops ready after a start, raises it with the label lat cycles later.
    initial begin
        mlp_ready = 1'b1;
        mlp_label = 8'h00;
        forever begin
            @(negedge clk);
            if (rst && mlp_start) begin
                start_cyc = cyc;
                #2 mlp_ready = 1'b0;
                if (hang) begin
                    while (hang) @(negedge clk);
                    #2 mlp_ready = 1'b1;
                end else begin
                    repeat (lat) @(negedge clk);
                    #2 mlp_label = cur_label;
                    mlp_ready = 1'b1;
                    rise_cyc = cyc;
                    rise_pending = 1'b1;
                end
            end
        end
    end

    // Compare process: results, start pulses and vectors against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (m_valid) begin
                if (exp_res.size() == 0) begin
                    chk("result_expected", 64'(exp_res.size()), 1);
                end else begin
                    chk("m_label", m_label, exp_res[0][7:0]);
                    chk("m_err", m_err, exp_res[0][8]);
                    if (m_ready) void'(exp_res.pop_front());
                end
            end
            if (mlp_start) begin
                start_cnt++;
                chk("start_single", prev_start, 0);
                chk("start_ready", mlp_ready, 1);
                if (exp_vec.size() == 0) chk("start_expected", 64'(exp_vec.size()), 1);
                else chk_vec("mlp_inp", mlp_inp, exp_vec.pop_front());
            end
            if (rise_pending && cyc == rise_cyc + 1) begin
                chk("valid_after_ready", m_valid, 1);
                rise_pending = 1'b0;
            end
            prev_start = mlp_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    // Frame of n bytes, s_last on the final byte if with_last; outcome depends only on length.
    task automatic send_frame(input int n, input bit with_last, input bit tmo);
        logic [NF*FW-1:0] v;
        bit ok;
        if (with_last) begin
            if (n == NF) begin
                v = '0;
                for (int i = 0; i < NF; i++) v[i*FW +: FW] = fbuf[i];
                exp_vec.push_back(v);
                exp_res.push_back(tmo ? {1'b1, 8'hFF} : {1'b0, cur_label});
            end else begin
                exp_res.push_back({1'b1, 8'hFF});
            end
        end
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            #1 s_valid = 1'b1;
            s_data = fbuf[i];
            s_last = with_last && (i == n - 1);
            ok = 1'b0;
            for (int g = 0; g < 500 && !ok; g++) begin
                @(negedge clk);
                ok = s_ready;
            end
            if (!ok) chk("s_ready_wait", s_ready, 1);
            @(posedge clk);
        end
        #1 s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int g = 0; g < 400 && !ok; g++) begin
            @(negedge clk);
            ok = (exp_res.size() == 0) && !m_valid && !busy;
        end
        chk("idle", ok, 1);
    endtask

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: got no finish want finish");
        finish_run();
    end

    initial begin
        int s0;
        bit ok;
        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_m_label", m_label, 0);
        chk("rst_start", mlp_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 1);
        chk_vec("rst_inp", mlp_inp, '0);
        #1 rst = 1'b1;

        // Nominal: bytes 0x01..0x3F, label 7 after ready is low for 10 cycles.
        for (int i = 0; i < NF; i++) fbuf[i] = 8'(i + 1);
        cur_label = 8'h07; lat = 10; s0 = start_cnt;
        send_frame(NF, 1, 0);
        @(negedge clk);
        chk("start_t1", mlp_start, 1);
        ok = 1'b0;
        for (int g = 0; g < 40 && !ok; g++) begin
            @(negedge clk);
            ok = m_valid;
        end
        chk("nom_valid", m_valid, 1);
        chk("nom_label", m_label, 8'h07);
        chk("nom_err", m_err, 0);
        wait_idle();
        chk("nom_starts", start_cnt - s0, 1);
        chk("nom_inp_lo", mlp_inp[7:0], 8'h01);
        chk("nom_inp_hi", mlp_inp[503:496], 8'h3F);

        // Short frame: s_last on byte index 5, then a normal frame.
        for (int i = 0; i < 128; i++) fbuf[i] = 8'(i + 8'h80);
        s0 = start_cnt;
        send_frame(6, 1, 0);
        @(negedge clk);
        chk("short_valid", m_valid, 1);
        chk("short_label", m_label, 8'hFF);
        chk("short_err", m_err, 1);
        wait_idle();
        chk("short_starts", start_cnt - s0, 0);
        cur_label = 8'h11; lat = 4;
        send_frame(NF, 1, 0);
        wait_idle();

        // Long frame: 63 bytes without s_last plus 4 drained bytes.
        for (int i = 0; i < 128; i++) fbuf[i] = 8'(3 * i + 5);
        s0 = start_cnt;
        send_frame(NF + 4, 1, 0);
        wait_idle();
        chk("long_starts", start_cnt - s0, 0);
        cur_label = 8'h42;
        send_frame(NF, 1, 0);
        wait_idle();
        chk("long_next_label", m_label, 8'h42);

        // Backpressure: m_ready low for 20 cycles while the result is held.
        for (int i = 0; i < NF; i++) fbuf[i] = 8'(8'hC0 ^ i);
        #1 m_ready = 1'b0;
        cur_label = 8'h33; lat = 3;
        send_frame(NF, 1, 0);
        ok = 1'b0;
        for (int g = 0; g < 40 && !ok; g++) begin
            @(negedge clk);
            ok = m_valid;
        end
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_valid", m_valid, 1);
            chk("bp_label", m_label, 8'h33);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_resume", s_ready, 1);
        chk("bp_valid_drop", m_valid, 0);
        wait_idle();

`ifdef MLP_LOADER_TIMEOUT_EN
        // Timeout: MLP never completes; next START stalls until ready returns.
        for (int i = 0; i < NF; i++) fbuf[i] = 8'(i * 7);
        hang = 1'b1;
        send_frame(NF, 1, 1);
        ok = 1'b0;
        for (int g = 0; g < 80 && !ok; g++) begin
            @(negedge clk);
            ok = m_valid;
        end
        chk("tmo_cycle", cyc - start_cyc, 17);
        chk("tmo_label", m_label, 8'hFF);
        chk("tmo_err", m_err, 1);
        wait_idle();
        cur_label = 8'h5A; lat = 5; s0 = start_cnt;
        send_frame(NF, 1, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("tmo_stall_start", mlp_start, 0);
            chk("tmo_stall_busy", busy, 1);
        end
        hang = 1'b0;
        wait_idle();
        chk("tmo_next_starts", start_cnt - s0, 1);
        chk("tmo_next_label", m_label, 8'h5A);
`endif

        // Reset mid-FILL after 30 bytes, then a full frame.
        for (int i = 0; i < NF; i++) fbuf[i] = 8'(i + 8'h40);
        send_frame(30, 0, 0);
        chk("pre_rst_inp", mlp_inp[7:0], 8'h40);
        #2 rst = 1'b0;
        #1;
        chk_vec("rst2_inp", mlp_inp, '0);
        chk("rst2_busy", busy, 0);
        chk("rst2_m_valid", m_valid, 0);
        chk("rst2_s_ready", s_ready, 1);
        chk("rst2_start", mlp_start, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < NF; i++) fbuf[i] = 8'(8'hFE - i);
        cur_label = 8'h2C; lat = 6;
        send_frame(NF, 1, 0);
        wait_idle();
        chk("rst2_label", m_label, 8'h2C);
        chk("rst2_inp_lo", mlp_inp[7:0], 8'hFE);

        finish_run();
    end

endmodule
